// File: rtl/sic1_sequencer.sv
//==============================================================================
// Module   : sic1_sequencer
// Purpose  : Instruction sequencer for the SIC-1 SUBLEQ core. Steps every
//            "subleq A B C" instruction through fetch, operand read, execute
//            and write over a single-port 256x8 memory with one-cycle read
//            latency. The I/O addresses are mapped onto an input valid/ready
//            handshake, an output valid/ready handshake and a halt flag.
// Ports    : clk, rst_n (async, active low), ena (global hold)
//            mem_addr/mem_re/mem_rdata/mem_we/mem_wdata : memory port
//            in_data/in_valid/in_ready                   : input stream
//            out_data/out_valid/out_ready                : output stream
//            halted, pc                                  : status
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sic1_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'd0,
    parameter logic [7:0] IN_ADDR   = 8'd253,
    parameter logic [7:0] OUT_ADDR  = 8'd254,
    parameter logic [7:0] HALT_ADDR = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [7:0] mem_addr,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       halted,
    output logic [7:0] pc
);

    localparam logic [2:0] FETCH_A  = 3'd0;
    localparam logic [2:0] FETCH_B  = 3'd1;
    localparam logic [2:0] FETCH_C  = 3'd2;
    localparam logic [2:0] READ_A   = 3'd3;
    localparam logic [2:0] READ_B   = 3'd4;
    localparam logic [2:0] EXEC     = 3'd5;
    localparam logic [2:0] OUT_WAIT = 3'd6;
    localparam logic [2:0] HALT     = 3'd7;

    logic [2:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] c_q, c_d;
    logic [7:0] ma_q, ma_d;
    logic [7:0] npc_q, npc_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    // Operand classification
    logic       w_a_is_in, w_a_is_out, w_a_is_io;
    logic       w_b_is_in, w_b_is_io;
    logic [7:0] w_mb;
    logic [7:0] w_r;
    logic [7:0] w_npc;
    logic       w_npc_halts;

    // Unqualified strobes; qualified with ena/rst_n at the port
    logic [7:0] w_addr;
    logic       w_re;
    logic       w_we;
    logic [7:0] w_wdata;
    logic       w_in_rdy;

    assign w_a_is_in  = (a_q == IN_ADDR);
    assign w_a_is_out = (a_q == OUT_ADDR);
    assign w_a_is_io  = w_a_is_in || w_a_is_out || (a_q == HALT_ADDR);
    assign w_b_is_in  = (b_q == IN_ADDR);
    assign w_b_is_io  = w_b_is_in || (b_q == OUT_ADDR) || (b_q == HALT_ADDR);

    // mB source: memory, input byte, or zero for OUT/HALT reads
    assign w_mb = w_b_is_io ? (w_b_is_in ? in_data : 8'h00) : mem_rdata;
    assign w_r  = ma_q - w_mb;

    // Branch when the result is <= 0 as a signed byte
    assign w_npc       = ((w_r == 8'h00) || w_r[7]) ? c_q : (pc_q + 8'd3);
    assign w_npc_halts = (w_npc == HALT_ADDR);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        ma_d        = ma_q;
        npc_d       = npc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        w_addr      = pc_q;
        w_re        = 1'b0;
        w_we        = 1'b0;
        w_wdata     = 8'h00;
        w_in_rdy    = 1'b0;

        case (state_q)
            FETCH_A: begin
                w_addr  = pc_q;
                w_re    = 1'b1;
                state_d = FETCH_B;
            end
            FETCH_B: begin
                a_d     = mem_rdata;
                w_addr  = pc_q + 8'd1;
                w_re    = 1'b1;
                state_d = FETCH_C;
            end
            FETCH_C: begin
                b_d     = mem_rdata;
                w_addr  = pc_q + 8'd2;
                w_re    = 1'b1;
                state_d = READ_A;
            end
            READ_A: begin
                c_d = mem_rdata;
                if (!w_a_is_io) begin
                    w_addr = a_q;
                    w_re   = 1'b1;
                end
                state_d = READ_B;
            end
            READ_B: begin
                w_in_rdy = w_a_is_in;
                if (!w_a_is_in || in_valid) begin
                    ma_d = w_a_is_io ? (w_a_is_in ? in_data : 8'h00) : mem_rdata;
                    if (!w_b_is_io) begin
                        w_addr = b_q;
                        w_re   = 1'b1;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                w_in_rdy = w_b_is_in;
                if (!w_b_is_in || in_valid) begin
                    if (!w_a_is_io) begin
                        w_we    = 1'b1;
                        w_addr  = a_q;
                        w_wdata = w_r;
                    end
                    if (w_a_is_out) begin
                        // Branch target is kept until the consumer takes the byte
                        out_data_d  = w_r;
                        out_valid_d = 1'b1;
                        npc_d       = w_npc;
                        state_d     = OUT_WAIT;
                    end else begin
                        pc_d    = w_npc;
                        state_d = w_npc_halts ? HALT : FETCH_A;
                    end
                end
            end
            OUT_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = npc_q;
                    state_d     = (npc_q == HALT_ADDR) ? HALT : FETCH_A;
                end
            end
            HALT: begin
                pc_d = HALT_ADDR;
            end
            default: begin
                state_d = FETCH_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_A;
            pc_q        <= RESET_PC;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            c_q         <= 8'h00;
            ma_q        <= 8'h00;
            npc_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            ma_q        <= ma_d;
            npc_q       <= npc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Memory strobes are suppressed while frozen so a held read cannot
    // overwrite mem_rdata and a held write is never repeated; both are also
    // forced low during reset so an aborted instruction never writes.
    assign mem_addr  = w_addr;
    assign mem_re    = w_re && ena && rst_n;
    assign mem_we    = w_we && ena && rst_n;
    assign mem_wdata = w_wdata;
    assign in_ready  = w_in_rdy;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == HALT);
    assign pc        = pc_q;

endmodule

`default_nettype wire

// File: doc/sic1_sequencer.md
Name: sic1_sequencer

Overview:
- Instruction sequencer for the SIC-1 SUBLEQ core: walks the fetch/read/execute/write phases of each "subleq A B C" instruction over a single-port 256x8 byte memory.
- Maps the I/O addresses (@IN, @OUT, @HALT) onto input/output valid-ready handshakes and a halt flag.
- Sits between the top-level pin mux (halt on a uio pin, active-low output strobe derived from out_valid) and the memory array.

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- IN_ADDR, 253, address whose reads consume one input byte.
- OUT_ADDR, 254, address whose writes emit one output byte; reads return 0.
- HALT_ADDR, 255, branch/next-PC target that halts; reads return 0, writes discarded.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  when 0, FSM and all registers hold; outputs keep their values.
- mem_addr  out  8  memory address.
- mem_re  out  1  read strobe; mem_rdata valid in the following cycle.
- mem_rdata  in  8  read data (one-cycle latency).
- mem_we  out  1  write strobe, same cycle as mem_addr/mem_wdata.
- mem_wdata  out  8  write data.
- in_data  in  8  input byte.
- in_valid  in  1  input byte available.
- in_ready  out  1  sequencer waiting for input.
- out_data  out  8  output byte.
- out_valid  out  1  output byte pending.
- out_ready  in  1  consumer accepts output.
- halted  out  1  core stopped.
- pc  out  8  current instruction address.

Behaviour:
- Reset (async, rst_n=0) → state FETCH_A, pc=RESET_PC, A/B/C/mA registers=0. All strobes 0, out_data=0, halted=0, mem_addr=0.
- I/O addresses: IO = {IN_ADDR, OUT_ADDR, HALT_ADDR}. mem_re and mem_we are never asserted with an IO address.
- All pc/address arithmetic is mod 256.
- FETCH_A: mem_addr=pc, mem_re=1 → FETCH_B.
- FETCH_B: A<=mem_rdata; mem_addr=pc+1, re=1 → FETCH_C.
- FETCH_C: B<=mem_rdata; mem_addr=pc+2, re=1 → READ_A.
- READ_A: C<=mem_rdata. If the new A is not IO: mem_addr=A, re=1. → READ_B.
- READ_B (resolve mA):
  - A is a memory address: mA<=mem_rdata.
  - A==IN_ADDR: in_ready=1; stay until in_valid=1, then mA<=in_data.
  - A==OUT_ADDR or HALT_ADDR: mA<=0.
  - In the completing cycle only, if B is not IO: mem_addr=B, re=1 → EXEC.
- EXEC (resolve mB):
  - mB source: mem_rdata; or in_data with the same in_ready/in_valid wait (stay in EXEC); or 0 for OUT_ADDR/HALT_ADDR.
  - r = mA - mB, 8-bit wrap. Combinational in the completing cycle.
  - A not IO: mem_we=1, mem_addr=A, mem_wdata=r.
  - A==OUT_ADDR: out_data<=r, out_valid<=1 → OUT_WAIT.
  - A==IN_ADDR or HALT_ADDR: write discarded.
  - npc = C if r as signed is <= 0 (r==0 or r[7]=1), else pc+3.
  - If not going to OUT_WAIT: pc<=npc → FETCH_A, or → HALT if npc==HALT_ADDR.
- OUT_WAIT: out_valid held and out_data stable until out_ready=1. In that cycle out_valid<=0, pc<=npc, next state per the npc rule. out_ready while out_valid=0 is ignored.
- HALT: halted=1, no strobes, pc=HALT_ADDR. Only reset exits.
- Timing: minimum 6 cycles per non-IO instruction; +1 cycle minimum with output; +wait cycles for input/output stalls.
- A==B==IN_ADDR consumes two input bytes, first as mA, second as mB.
- in_ready drops in the cycle after the transfer. in_valid outside a wait state is ignored.
- ena=0 mid-handshake: no transfer counted that cycle, even if in_valid/out_ready are high.
- Reset mid-instruction or mid-handshake aborts immediately. No partial write completes after reset.

Test Plan:
- mem[0..2]={6,7,3}, mem[6]=5, mem[7]=3 → mem[6]=2 written in cycle 6, branch not taken, pc=3 at cycle 6 edge; mem_re pattern pc,pc+1,pc+2,6,7.
- mem[0..2]={6,6,9} → mem[6]=0, pc=9; with mem[6]=0x80, mem[7]=1 in {6,7,9}: r=0x7F positive → pc=3 (wrap/sign check).
- {254,253,255}, in_valid delayed 4 cycles, in_data=0x05 → in_ready high 5 cycles; out_data=0xFB, out_valid held through 3 cycles of out_ready=0; then halted=1, pc=255.
- {253,253,0} with inputs 0x10, 0x03 → two handshakes; r=0x0D; no mem_we (write to IN_ADDR discarded); pc=3.
- pc=252, instruction with r>0 → pc wraps to 255 → HALT; halted stays 1 for 20 cycles, no strobes.
- ena=0 for 3 cycles mid-READ_B and rst_n pulse in OUT_WAIT → state frozen, then clean restart at RESET_PC with all outputs 0.
